cpu_mem_access: RTL and testbench

Load/store bus stage of the MIPS CPU: sits directly downstream of the ALU and takes its effective address, the opcode and the rt store value. It runs one Avalon-MM read or write per memory instruction and handles waitrequest stalls. On the way out it drives big-endian byte-lane enables and shifted store data. On the way back it extracts, sign- or zero-extends and registers the load result for register-file writeback.

---
 rtl/cpu_mem_access_pkg.sv | 59 +++++
 rtl/cpu_mem_lane.sv | 67 ++++++
 rtl/cpu_mem_access.sv | 143 ++++++++++++++
 tb/tb_cpu_mem_access.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_access_pkg.sv
// Shared codes for the CPU load/store bus stage: MIPS memory opcodes,
// the bus FSM state type, byte-lane enable constants and small opcode
// classification helpers used by the FSM and the lane steering logic.
package cpu_mem_access_pkg;

   // MIPS primary opcodes for the memory instructions handled by this stage
   typedef enum logic [5:0] {
      OP_LB  = 6'h20,
      OP_LH  = 6'h21,
      OP_LW  = 6'h23,
      OP_LBU = 6'h24,
      OP_LHU = 6'h25,
      OP_SB  = 6'h28,
      OP_SH  = 6'h29,
      OP_SW  = 6'h2B
   } opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE
   } mem_state_t;

   // Big-endian lane enables: bit 3 carries byte offset 0 (bits [31:24])
   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_BYTE0   = 4'b1000;

   function automatic logic is_load(opcode_t op);
      return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
   endfunction

   function automatic logic is_store(opcode_t op);
      return op inside {OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic logic is_half(opcode_t op);
      return op inside {OP_LH, OP_LHU, OP_SH};
   endfunction

   function automatic logic is_word(opcode_t op);
      return op inside {OP_LW, OP_SW};
   endfunction

   // Byte offset with the low bits forced to the access's natural alignment
   function automatic logic [1:0] aligned_offset(opcode_t op, logic [1:0] addr_lo);
      if (is_word(op))      return 2'b00;
      else if (is_half(op)) return {addr_lo[1], 1'b0};
      else                  return addr_lo;
   endfunction

   // True when a halfword/word access is not naturally aligned
   function automatic logic misaligned(opcode_t op, logic [1:0] addr_lo);
      return (is_half(op) && addr_lo[0]) || (is_word(op) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/cpu_mem_lane.sv
// Combinational byte-lane steering for the load/store stage: big-endian
// lane enables, store data replicated across lanes, and load data
// extraction with sign/zero extension.
module cpu_mem_lane
   import cpu_mem_access_pkg::*;
(
   input  opcode_t     opcode,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] readdata,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   output logic [31:0] load_data
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   // Offset 0 is the most significant byte, so shift right by (3 - offset) bytes
   assign rd_byte = 8'(readdata >> {~offset, 3'b000});
   assign rd_half = offset[1] ? readdata[15:0] : readdata[31:16];

   // Lane enables, store replication and load extension per opcode
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      byteenable = 4'b0000;
      writedata  = 32'h0;
      load_data  = 32'h0;
      case (opcode)
         OP_LB: begin
            byteenable = BE_BYTE0 >> offset;
            load_data  = {{24{rd_byte[7]}}, rd_byte};
         end
         OP_LBU: begin
            byteenable = BE_BYTE0 >> offset;
            load_data  = {24'h0, rd_byte};
         end
         OP_LH: begin
            byteenable = offset[1] ? BE_HALF_LO : BE_HALF_HI;
            load_data  = {{16{rd_half[15]}}, rd_half};
         end
         OP_LHU: begin
            byteenable = offset[1] ? BE_HALF_LO : BE_HALF_HI;
            load_data  = {16'h0, rd_half};
         end
         OP_LW: begin
            byteenable = BE_WORD;
            load_data  = readdata;
         end
         OP_SB: begin
            byteenable = BE_BYTE0 >> offset;
            writedata  = {4{store_data[7:0]}};
         end
         OP_SH: begin
            byteenable = offset[1] ? BE_HALF_LO : BE_HALF_HI;
            writedata  = {2{store_data[15:0]}};
         end
         OP_SW: begin
            byteenable = BE_WORD;
            writedata  = store_data;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/cpu_mem_access.sv
// Load/store bus stage: runs one Avalon-MM read or write per memory
// instruction, honours waitrequest stalls, and registers the extended load
// result for writeback. Optional watchdog via TIMEOUT_CYCLES (0 = off).
// Build option: define CPU_MEM_ALIGN_CHECK_EN to fault misaligned
// halfword/word accesses instead of masking the low address bits.
module cpu_mem_access
   import cpu_mem_access_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset_ni,
   input  logic        start_i,
   input  opcode_t     opcode_i,
   input  logic [31:0] address_i,
   input  logic [31:0] store_data_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        fault_o,
   output logic [31:0] load_data_o,
   output logic [31:0] avm_address_o,
   output logic        avm_read_o,
   output logic        avm_write_o,
   output logic [3:0]  avm_byteenable_o,
   output logic [31:0] avm_writedata_o,
   input  logic [31:0] avm_readdata_i,
   input  logic        avm_waitrequest_i
);

`ifdef CPU_MEM_ALIGN_CHECK_EN
   localparam bit ALIGN_CHECK = 1'b1;
`else
   localparam bit ALIGN_CHECK = 1'b0;
`endif

   mem_state_t  state;
   opcode_t     opcode_q;
   logic [1:0]  offset_q;
   logic [31:0] wait_cnt;

   opcode_t     lane_opcode;
   logic [1:0]  lane_offset;
   logic [3:0]  lane_be;
   logic [31:0] lane_wd;
   logic [31:0] lane_ld;
   logic        timeout_hit;

   // In IDLE the lanes see the incoming request so the bus outputs can be
   // registered at start; afterwards they see the captured request so the
   // read data is extracted with the right opcode/offset.
   assign lane_opcode = (state == ST_IDLE) ? opcode_i : opcode_q;
   assign lane_offset = (state == ST_IDLE) ? aligned_offset(opcode_i, address_i[1:0]) : offset_q;

   // This stall cycle is the TIMEOUT_CYCLES-th in a row
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_CYCLES - 32'd1);

   cpu_mem_lane u_lane (
      .opcode     (lane_opcode),
      .offset     (lane_offset),
      .store_data (store_data_i),
      .readdata   (avm_readdata_i),
      .byteenable (lane_be),
      .writedata  (lane_wd),
      .load_data  (lane_ld)
   );

   // Bus FSM with capture registers, watchdog and registered outputs
   always_ff @(posedge clk or negedge reset_ni) begin
      // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
      if (!reset_ni) begin
         state            <= ST_IDLE;
         opcode_q         <= opcode_t'(6'h00);
         offset_q         <= 2'b00;
         wait_cnt         <= 32'h0;
         busy_o           <= 1'b0;
         done_o           <= 1'b0;
         fault_o          <= 1'b0;
         load_data_o      <= 32'h0;
         avm_address_o    <= 32'h0;
         avm_read_o       <= 1'b0;
         avm_write_o      <= 1'b0;
         avm_byteenable_o <= 4'b0000;
         avm_writedata_o  <= 32'h0;
      end else begin
         done_o  <= 1'b0;
         fault_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  opcode_q         <= opcode_i;
                  offset_q         <= aligned_offset(opcode_i, address_i[1:0]);
                  avm_address_o    <= {address_i[31:2], 2'b00};
                  avm_byteenable_o <= lane_be;
                  avm_writedata_o  <= lane_wd;
                  wait_cnt         <= 32'h0;
                  if (ALIGN_CHECK && misaligned(opcode_i, address_i[1:0])) begin
                     state   <= ST_DONE;
                     done_o  <= 1'b1;
                     fault_o <= 1'b1;
                  end else if (is_load(opcode_i)) begin
                     state      <= ST_READ;
                     avm_read_o <= 1'b1;
                     busy_o     <= 1'b1;
                  end else if (is_store(opcode_i)) begin
                     state       <= ST_WRITE;
                     avm_write_o <= 1'b1;
                     busy_o      <= 1'b1;
                  end else begin
                     state  <= ST_DONE;
                     done_o <= 1'b1;
                  end
               end
            end
            ST_READ, ST_WRITE: begin
               if (!avm_waitrequest_i) begin
                  if (state == ST_READ) load_data_o <= lane_ld;
                  state       <= ST_DONE;
                  done_o      <= 1'b1;
                  busy_o      <= 1'b0;
                  avm_read_o  <= 1'b0;
                  avm_write_o <= 1'b0;
               end else if (timeout_hit) begin
                  state       <= ST_DONE;
                  done_o      <= 1'b1;
                  fault_o     <= 1'b1;
                  busy_o      <= 1'b0;
                  avm_read_o  <= 1'b0;
                  avm_write_o <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + 32'd1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_mem_access.sv
// Self-checking bench for cpu_mem_access: a bench-side model predicts bus
// signals per stall cycle and pushes the completion result (latency, fault,
// load data) to a scoreboard popped on done_o.
module tb_cpu_mem_access;
   import cpu_mem_access_pkg::*;

   localparam int TO = 4;
`ifdef CPU_MEM_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_ni = 1'b0;
   logic        start_i = 1'b0;
   opcode_t     opcode_i = OP_LW;
   logic [31:0] address_i = 32'h0;
   logic [31:0] store_data_i = 32'h0;
   logic        busy_o, done_o, fault_o;
   logic [31:0] load_data_o, avm_address_o, avm_writedata_o;
   logic        avm_read_o, avm_write_o;
   logic [3:0]  avm_byteenable_o;
   logic [31:0] avm_readdata_i = 32'h0;
   logic        avm_waitrequest_i = 1'b0;

   cpu_mem_access #(.TIMEOUT_CYCLES(TO)) dut (
      .clk               (clk),
      .reset_ni          (reset_ni),
      .start_i           (start_i),
      .opcode_i          (opcode_i),
      .address_i         (address_i),
      .store_data_i      (store_data_i),
      .busy_o            (busy_o),
      .done_o            (done_o),
      .fault_o           (fault_o),
      .load_data_o       (load_data_o),
      .avm_address_o     (avm_address_o),
      .avm_read_o        (avm_read_o),
      .avm_write_o       (avm_write_o),
      .avm_byteenable_o  (avm_byteenable_o),
      .avm_writedata_o   (avm_writedata_o),
      .avm_readdata_i    (avm_readdata_i),
      .avm_waitrequest_i (avm_waitrequest_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   typedef struct {
      logic [31:0] load;
      logic        fault;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] load_model = 32'h0;

   function automatic int size_of(opcode_t op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 1;
         OP_LH, OP_LHU, OP_SH: return 2;
         OP_LW, OP_SW:         return 4;
         default:              return 0;
      endcase
   endfunction

   function automatic bit is_ld(opcode_t op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
   endfunction

   task automatic check_idle_outputs(input string tag);
      check({tag, "_read"},  avm_read_o, 0);
      check({tag, "_write"}, avm_write_o, 0);
      check({tag, "_busy"},  busy_o, 0);
      check({tag, "_done"},  done_o, 0);
      check({tag, "_fault"}, fault_o, 0);
      check({tag, "_load"},  load_data_o, 0);
      check({tag, "_addr"},  avm_address_o, 0);
      check({tag, "_be"},    avm_byteenable_o, 0);
      check({tag, "_wd"},    avm_writedata_o, 0);
   endtask

   // One access: predict, push to scoreboard, drive, check each cycle, pop on done
   task automatic run_access(input opcode_t op, input logic [31:0] addr, input logic [31:0] sd,
                             input logic [31:0] rd, input int waits);
      int          sz, n_strobe;
      bit          ld, mis, bus, tmo, seen;
      logic [1:0]  off;
      logic [3:0]  be;
      logic [31:0] wd, ext;
      logic [15:0] h;
      logic [7:0]  bytes [4];
      exp_t        e;

      sz  = size_of(op);
      ld  = is_ld(op);
      mis = ALIGN_EN && ((sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00));
      bus = (sz != 0) && !mis;
      tmo = bus && (waits >= TO);
      n_strobe = !bus ? 0 : (tmo ? TO : waits + 1);

      off = addr[1:0];
      if (sz == 2) off[0] = 1'b0;
      if (sz == 4) off = 2'b00;

      case (sz)
         1: case (off)
               2'd0: be = 4'b1000;
               2'd1: be = 4'b0100;
               2'd2: be = 4'b0010;
               default: be = 4'b0001;
            endcase
         2: be = (off == 2'd0) ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase

      case (op)
         OP_SB:   wd = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
         OP_SH:   wd = {sd[15:0], sd[15:0]};
         default: wd = sd;
      endcase

      bytes[0] = rd[31:24];
      bytes[1] = rd[23:16];
      bytes[2] = rd[15:8];
      bytes[3] = rd[7:0];
      h = (off == 2'd0) ? {bytes[0], bytes[1]} : {bytes[2], bytes[3]};
      case (op)
         OP_LB:   ext = {{24{bytes[off][7]}}, bytes[off]};
         OP_LBU:  ext = {24'h0, bytes[off]};
         OP_LH:   ext = {{16{h[15]}}, h};
         OP_LHU:  ext = {16'h0, h};
         default: ext = rd;
      endcase

      if (bus && ld && !tmo) load_model = ext;
      e.load  = load_model;
      e.fault = mis || tmo;
      e.lat   = bus ? n_strobe + 1 : 1;
      sb.push_back(e);

      @(negedge clk);
      start_i           = 1'b1;
      opcode_i          = op;
      address_i         = addr;
      store_data_i      = sd;
      avm_readdata_i    = rd;
      avm_waitrequest_i = 1'b0;

      seen = 1'b0;
      for (int c = 1; c <= 60 && !seen; c++) begin
         @(negedge clk);
         start_i = 1'b0;
         if (c <= n_strobe) begin
            check("strobe_read",  avm_read_o, ld);
            check("strobe_write", avm_write_o, !ld);
            check("bus_addr",     avm_address_o, {addr[31:2], 2'b00});
            check("bus_be",       avm_byteenable_o, be);
            if (!ld) check("bus_wd", avm_writedata_o, wd);
            check("bus_busy",     busy_o, 1);
            check("bus_nodone",   done_o, 0);
         end
         avm_waitrequest_i = (c <= waits);
         if (done_o) begin
            seen = 1'b1;
            e = sb.pop_front();
            check("done_latency", c, e.lat);
            check("done_fault",   fault_o, e.fault);
            check("done_load",    load_data_o, e.load);
            check("done_busy",    busy_o, 0);
            check("done_read",    avm_read_o, 0);
            check("done_write",   avm_write_o, 0);
         end
      end
      if (!seen) begin
         check("done_seen", 0, 1);
         void'(sb.pop_front());
      end
      avm_waitrequest_i = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      reset_ni = 1'b1;
      @(negedge clk);

      // Main function
      run_access(OP_LW,  32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 0);
      run_access(OP_LB,  32'h0000_1003, 32'h0, 32'h0000_00F0, 0);
      run_access(OP_LBU, 32'h0000_1003, 32'h0, 32'h0000_00F0, 0);
      run_access(OP_SH,  32'h0000_2002, 32'h0000_4142, 32'h0, 3);
      run_access(OP_LW,  32'h0000_1002, 32'h0, 32'h0BAD_F00D, 0);
      run_access(OP_LH,  32'h0000_1000, 32'h0, 32'h8001_7FFE, 1);
      run_access(OP_LHU, 32'h0000_1002, 32'h0, 32'h1234_8765, 0);
      run_access(OP_LH,  32'h0000_1001, 32'h0, 32'hF00F_1234, 0);
      run_access(OP_SB,  32'h0000_3001, 32'h1234_56AB, 32'h0, 1);
      run_access(OP_SW,  32'h0000_3000, 32'hCAFE_F00D, 32'h0, 2);
      run_access(opcode_t'(6'h0F), 32'h0000_1000, 32'h0, 32'h5555_5555, 0);

      // Watchdog: waitrequest stuck high
      run_access(OP_LW, 32'h0000_5000, 32'h0, 32'h7777_7777, 10);
      run_access(OP_SW, 32'h0000_5004, 32'h1111_2222, 32'h0, 10);

      // start_i while in DONE is ignored
      start_i   = 1'b1;
      opcode_i  = OP_LW;
      address_i = 32'h0000_6000;
      @(negedge clk);
      check("done_start_read", avm_read_o, 0);
      check("done_start_busy", busy_o, 0);
      start_i = 1'b0;
      @(negedge clk);
      check("done_start_ignored", avm_read_o, 0);

      // Randomised loads
      for (int i = 0; i < 6; i++) begin
         opcode_t rop;
         case ($urandom_range(0, 4))
            0: rop = OP_LB;
            1: rop = OP_LBU;
            2: rop = OP_LH;
            3: rop = OP_LHU;
            default: rop = OP_LW;
         endcase
         run_access(rop, $urandom, 32'h0, $urandom, int'($urandom_range(0, 2)));
      end

      // Reset during a stalled read
      @(negedge clk);
      start_i           = 1'b1;
      opcode_i          = OP_LW;
      address_i         = 32'h0000_4000;
      avm_waitrequest_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("pre_reset_read", avm_read_o, 1);
      @(negedge clk);
      reset_ni = 1'b0;
      #1;
      check_idle_outputs("midreset");
      load_model = 32'h0;
      @(negedge clk);
      reset_ni          = 1'b1;
      avm_waitrequest_i = 1'b0;
      run_access(OP_LW, 32'h0000_1000, 32'h0, 32'h1357_9BDF, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
